// File: rtl/pc_pkg.sv
// Shared definitions for the program counter: operation encoding, default
// parameter values and the per-cycle request priority resolver.
package pc_pkg;

  localparam int DEFAULT_WIDTH       = 16;
  localparam int DEFAULT_STEP        = 1;
  localparam int DEFAULT_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_LOAD = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } pc_op_e;

  // Reset is handled by the register itself; below it the order is
  // load > call > ret > inc > hold, and only the winner has any effect.
  function automatic pc_op_e resolve_op(input logic load,
                                        input logic call,
                                        input logic ret,
                                        input logic inc);
    if (load)      return OP_LOAD;
    else if (call) return OP_CALL;
    else if (ret)  return OP_RET;
    else if (inc)  return OP_INC;
    else           return OP_HOLD;
  endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. Push when full and pop when empty are ignored;
// empty/full are registered and change in the same cycle as the pointer.
module return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(DEPTH + 1);
  localparam logic [SW-1:0] SP_FULL = SW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [SW-1:0]    sp_q, sp_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign wr_idx = AW'(sp_q);
  assign rd_idx = AW'(sp_q - SW'(1));
  assign dout   = mem_q[rd_idx];
  assign empty  = empty_q;
  assign full   = full_q;

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (push && !full_q) begin
      mem_d[wr_idx] = din;
      sp_d          = sp_q + SW'(1);
    end else if (pop && !empty_q) begin
      sp_d = sp_q - SW'(1);
    end
    empty_d = (sp_d == '0);
    full_d  = (sp_d == SP_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Entry contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_stack_counter.sv
// Program counter with hold/inc/load/call/ret and a return-address stack.
// Optional wrap pulse on increment overflow is enabled by PC_WRAP_DETECT_EN.
module pc_stack_counter
  import pc_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int STEP        = DEFAULT_STEP,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] out,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             overflow_err,
  output logic             underflow_err,
  output logic             wrapped
);

  pc_op_e           op;
  logic [WIDTH-1:0] out_q, out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] seq_val;
  logic             stk_push, stk_pop;
  logic [WIDTH-1:0] stk_dout;
  logic             stk_empty, stk_full;

  assign op = resolve_op(load, call, ret, inc);

  // seq_val is both the increment result and the call return address.
`ifdef PC_WRAP_DETECT_EN
  logic carry;
  logic wrapped_q, wrapped_d;

  assign {carry, seq_val} = {1'b0, out_q} + (WIDTH + 1)'(STEP);
  assign wrapped_d        = (op == OP_INC) && carry;
  assign wrapped          = wrapped_q;

  always_ff @(posedge clk) begin
    if (reset) wrapped_q <= 1'b0;
    else       wrapped_q <= wrapped_d;
  end
`else
  assign seq_val = out_q + WIDTH'(STEP);
  assign wrapped = 1'b0;
`endif

  always_comb begin
    out_d       = out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    case (op)
      OP_INC:  out_d = seq_val;
      OP_LOAD: out_d = load_val;
      OP_CALL: begin
        out_d = load_val;
        if (stk_full) overflow_d = 1'b1;
        else          stk_push   = 1'b1;
      end
      OP_RET: begin
        if (stk_empty) begin
          underflow_d = 1'b1;
        end else begin
          out_d   = stk_dout;
          stk_pop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (seq_val),
    .dout  (stk_dout),
    .empty (stk_empty),
    .full  (stk_full)
  );

  assign out           = out_q;
  assign stack_empty   = stk_empty;
  assign stack_full    = stk_full;
  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

endmodule
